// File: rtl/riscv_pkg.sv
// Shared RV32I load/store constants and LSU state encoding.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StLoadResp   = 2'd1,
        StStoreMerge = 2'd2
    } lsu_state_e;

    // Misaligned access or a funct3 with no meaning for the access direction.
    function automatic logic lsu_is_fault(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic f;
        f = 1'b0;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_H:    f = offset[0];
            F3_W:    f = (offset != 2'b00);
            F3_BU:   f = write;
            F3_HU:   f = write | offset[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_bit_sel;

    assign w_bit_sel = {i_offset, 3'b000};
    assign w_byte    = i_word[w_bit_sel +: 8];
    assign w_half    = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_HU:   o_load_data = {16'h0000, w_half};
            default: o_load_data = i_word;
        endcase
    end

    always_comb begin
        o_merge_data = i_word;
        if (i_funct3 == F3_B) begin
            o_merge_data[w_bit_sel +: 8] = i_wdata[7:0];
        end else if (i_funct3 == F3_H) begin
            if (i_offset[1]) begin
                o_merge_data[31:16] = i_wdata;
            end else begin
                o_merge_data[15:0] = i_wdata;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: word-indexed memory access, RMW for SB/SH, load alignment.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  load_valid,
    output logic [31:0]           load_data,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    lsu_state_e            r_state;
    lsu_state_e            w_state_next;
    logic [2:0]            r_funct3;
    logic [1:0]            r_offset;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [15:0]           r_wdata;

    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_fault;
    logic                  w_latch;
    logic [31:0]           w_load_data;
    logic [31:0]           w_merge_data;
    logic                  w_unused_addr;

    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign w_index       = req_addr[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];
    assign w_fault       = lsu_is_fault(req_write, req_funct3, req_addr[1:0]);

    lsu_lane_align u_lane_align (
        .i_offset     (r_offset),
        .i_funct3     (r_funct3),
        .i_word       (mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        stall        = 1'b0;
        load_valid   = 1'b0;
        load_data    = '0;
        fault        = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_wdata    = '0;
        case (r_state)
            StIdle: begin
                // Gate on rst_n so every output is quiet while reset is held.
                if (req_valid && rst_n) begin
                    if (w_fault) begin
                        fault = 1'b1;
                    end else if (req_write && (req_funct3 == F3_W)) begin
                        mem_we    = 1'b1;
                        mem_addr  = w_index;
                        mem_wdata = req_wdata;
                    end else begin
                        mem_re       = 1'b1;
                        mem_addr     = w_index;
                        stall        = 1'b1;
                        w_latch      = 1'b1;
                        w_state_next = req_write ? StStoreMerge : StLoadResp;
                    end
                end
            end
            StLoadResp: begin
                load_valid   = 1'b1;
                load_data    = w_load_data;
                w_state_next = StIdle;
            end
            StStoreMerge: begin
                mem_we       = 1'b1;
                mem_addr     = r_index;
                mem_wdata    = w_merge_data;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_funct3 <= '0;
            r_offset <= '0;
            r_index  <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_funct3 <= req_funct3;
                r_offset <= req_addr[1:0];
                r_index  <= w_index;
                r_wdata  <= req_wdata[15:0];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 1-cycle-latency word memory.
module tb_load_store_unit;

    localparam int unsigned AW = 11;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          stall;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          fault;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    int            wr_count;
    int            n_tests;
    int            n_fail;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .fault      (fault),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read register only updates on read cycles.
    initial wr_count = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end else if (mem_re) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic go_idle();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
    endtask

    task automatic test_reset();
        int wr_before;
        @(negedge clk);
        n_tests++;
        if ({stall, load_valid, fault, mem_we, mem_re} !== 5'b0 ||
            load_data !== 32'h0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctl=%b ld=%h addr=%h wd=%h, want all zero",
                     {stall, load_valid, fault, mem_we, mem_re}, load_data, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b1, 3'b010, 32'h10, 32'h12345678);
        @(negedge clk);
        go_idle();
        @(negedge clk);
        wr_before = wr_count;
        issue(1'b1, 3'b000, 32'h10, 32'h0000005A);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        go_idle();
        #1;
        n_tests++;
        if ({stall, load_valid, fault, mem_we, mem_re} !== 5'b0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_merge_outputs: got ctl=%b wd=%h, want 0",
                     {stall, load_valid, fault, mem_we, mem_re}, mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (wr_count !== wr_before) begin
            n_fail++;
            $display("FAIL reset_no_write: got %0d writes, want 0", wr_count - wr_before);
        end
        n_tests++;
        if (mem[4] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL reset_word_kept: got %h want 12345678", mem[4]);
        end
    endtask

    task automatic test_sw_lw();
        @(negedge clk);
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        #1;
        n_tests++;
        if (stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 11'd8 || mem_wdata !== 32'hDEADBEEF)
        begin
            n_fail++;
            $display("FAIL sw_issue: got st=%b we=%b a=%h d=%h want 0 1 008 deadbeef",
                     stall, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        #1;
        n_tests++;
        if (stall !== 1'b1 || mem_re !== 1'b1 || load_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_issue: got st=%b re=%b lv=%b want 1 1 0", stall, mem_re, load_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (load_valid !== 1'b1 || stall !== 1'b0 || load_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_resp: got lv=%b st=%b d=%h want 1 0 deadbeef",
                     load_valid, stall, load_data);
        end
        @(negedge clk);
        go_idle();
        #1;
        n_tests++;
        if (load_valid !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_after: got lv=%b st=%b want 0 0", load_valid, stall);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adr [4] = '{32'h43, 32'h43, 32'h42, 32'h40};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        @(negedge clk);
        issue(1'b1, 3'b010, 32'h40, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue(1'b0, f3[i], adr[i], 32'h0);
            @(negedge clk);
            #1;
            n_tests++;
            if (load_valid !== 1'b1 || load_data !== exp[i]) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: got lv=%b d=%h want 1 %h",
                         i, load_valid, load_data, exp[i]);
            end
        end
        @(negedge clk);
        go_idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(1'b1, 3'b010, 32'h30, 32'h11223344);
        @(negedge clk);
        issue(1'b1, 3'b000, 32'h31, 32'h000000AA);
        #1;
        n_tests++;
        if (stall !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_issue: got st=%b re=%b we=%b want 1 1 0", stall, mem_re, mem_we);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (mem_we !== 1'b1 || stall !== 1'b0 || mem_addr !== 11'd12 ||
            mem_wdata !== 32'h1122AA44) begin
            n_fail++;
            $display("FAIL sb_merge: got we=%b st=%b a=%h d=%h want 1 0 00c 1122aa44",
                     mem_we, stall, mem_addr, mem_wdata);
        end
        @(negedge clk);
        issue(1'b1, 3'b001, 32'h32, 32'h0000BEEF);
        @(negedge clk);
        @(negedge clk);
        issue(1'b0, 3'b010, 32'h30, 32'h0);
        @(negedge clk);
        #1;
        n_tests++;
        if (load_valid !== 1'b1 || load_data !== 32'hBEEFAA44) begin
            n_fail++;
            $display("FAIL merge_readback: got lv=%b d=%h want 1 beefaa44", load_valid, load_data);
        end
        @(negedge clk);
        go_idle();
    endtask

    task automatic test_faults();
        logic        wr  [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3  [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] adr [3] = '{32'h21, 32'h23, 32'h20};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(wr[i], f3[i], adr[i], 32'hFFFFFFFF);
            #1;
            n_tests++;
            if (fault !== 1'b1 || stall !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
                n_fail++;
                $display("FAIL fault[%0d]: got f=%b st=%b we=%b re=%b want 1 0 0 0",
                         i, fault, stall, mem_we, mem_re);
            end
            @(negedge clk);
            go_idle();
            #1;
            n_tests++;
            if (fault !== 1'b0 || load_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_pulse[%0d]: got f=%b lv=%b want 0 0", i, fault, load_valid);
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        issue(1'b1, 3'b010, 32'h2004, 32'hCAFEF00D);
        #1;
        n_tests++;
        if (mem_addr !== 11'd1 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_addr: got a=%h we=%b want 001 1", mem_addr, mem_we);
        end
        @(negedge clk);
        go_idle();
        n_tests++;
        if (mem[1] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL wrap_write: got %h want cafef00d", mem[1]);
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        go_idle();
        test_reset();
        test_sw_lw();
        test_loads();
        test_back_to_back();
        test_faults();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage load/store unit sitting directly upstream of the word-wide synchronous data memory. Converts RV32I loads and stores (byte address, funct3) into word-indexed memory accesses, performs read-modify-write for SB/SH because the memory has no byte enables, and extracts/sign-extends load results. Stalls the pipeline one cycle for every load and every sub-word store; SW completes without a stall.

## Interface
- ADDR_WIDTH, 11, word-address width of the data memory (2048 words)
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage holds a load or store
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101)
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold IF..MEM this cycle
- load_valid  out  1  load_data is valid this cycle
- load_data  out  32  aligned, extended load result
- fault  out  1  misaligned or illegal funct3; one-cycle pulse
- mem_addr  out  ADDR_WIDTH  word index to data memory
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after a non-write access

## Operation
- Word index = req_addr[ADDR_WIDTH+1:2]; upper bits ignored (wraps modulo memory size).
- States: IDLE, LOAD_RESP, STORE_MERGE.
- IDLE, no req_valid: all mem_* and status outputs 0.
- IDLE, fault condition (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 011/110/111; store funct3 >=011): fault=1, no memory access, no stall, stay IDLE.
- IDLE, SW: mem_we=1, mem_wdata=req_wdata, stall=0, stay IDLE.
- IDLE, load: mem_re=1, stall=1; latch funct3 and addr[1:0]; -> LOAD_RESP.
- LOAD_RESP: load_valid=1, stall=0; load_data = lane of mem_rdata selected by latched offset (byte = offset*8, half = offset[1]*16), sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW; -> IDLE. Request input ignored this cycle (pipeline still presents the same instruction).
- IDLE, SB/SH: mem_re=1, stall=1; latch word index, offset, funct3, req_wdata; -> STORE_MERGE.
- STORE_MERGE: mem_addr = latched index, mem_we=1, mem_wdata = mem_rdata with target byte/half replaced by req_wdata[7:0]/[15:0]; stall=0; -> IDLE.
- Load and store requests never overlap; one access outstanding at most.

## Timing
- rst_n low: state IDLE immediately; stall, load_valid, fault, mem_we, mem_re 0; load_data, mem_addr, mem_wdata 0. Reset during LOAD_RESP or STORE_MERGE abandons the access; pending RMW write is never issued.
- Load: 1 stall cycle, data on cycle 2 (memory read latency 1).
- SB/SH: 1 stall cycle, write lands at end of cycle 2.
- SW, fault: 0 stall cycles.
- Back-to-back: SB then LW to same word — LW read issued after merge write, returns merged value.
- mem_rdata only sampled in LOAD_RESP / STORE_MERGE; memory's read register is not updated on write cycles and must not be relied on elsewhere.
- stall, fault, mem_* are combinational from state and request; no combinational path from mem_rdata to stall.

## Structure
- Shared package riscv_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), lsu state encoding.
- Sub-module lsu_lane_align: combinational load extraction and store merge given offset, funct3, word; instantiated once for each path or shared.

## Test plan
- Reset: rst_n low mid STORE_MERGE (SB 0x5A to addr 0x10) -> mem_we never pulses, word at index 4 unchanged, all outputs 0.
- SW 0xDEADBEEF to 0x20, then LW 0x20 -> no stall on SW; load_valid one cycle after request with load_data 0xDEADBEEF, stall exactly one cycle.
- Word 0x80FF7F01 at 0x40: LB 0x43 -> 0xFFFFFF80; LBU 0x43 -> 0x00000080; LH 0x42 -> 0xFFFF80FF; LHU 0x40 -> 0x00007F01.
- Word 0x11223344 at 0x30: SB 0xAA to 0x31 then SH 0xBEEF to 0x32 -> LW 0x30 returns 0xBEEFAA44.
- LW 0x21, SH 0x23, load funct3 011 -> fault pulses 1 cycle each, no stall, mem_we/mem_re stay 0.
- Address 0x2004 with ADDR_WIDTH=11 -> mem_addr = 1 (wrap), SW writes word index 1.
